// File: rtl/vga_capture_pkg.sv
// Shared timing helpers, default 640x480@60 constants and FSM state type for vga_capture.
package vga_capture_pkg;

  // Total length of a line or frame: active + front porch + sync + back porch.
  function automatic int unsigned span_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  // Default 640x480@60 timing.
  localparam int unsigned H_TOTAL     = span_total(640, 16, 96, 48);
  localparam int unsigned V_TOTAL     = span_total(480, 10, 2, 33);
  localparam int unsigned H_ACT_START = 96 + 48;
  // The source toggles vsync at the start of horizontal active, so the line
  // counter restarts one line late; the active region starts one line earlier.
  localparam int unsigned V_ACT_START = 2 + 33 - 1;

  typedef enum logic {SEARCH, SYNCED} cap_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Registers a sync input, keeps a delayed copy and flags the falling edge.
module vga_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sync,
  output logic o_fall
);

  logic r_q;
  logic r_q_d;

  // Capture stage plus delayed copy; reset loads the idle (high) sync level.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q   <= 1'b1;
      r_q_d <= 1'b1;
    end else begin
      r_q   <= i_sync;
      r_q_d <= r_q;
    end
  end

  assign o_fall = ~r_q & r_q_d;

endmodule

// File: rtl/vga_capture.sv
// VGA receiver: recovers pixel coordinates and grayscale values from hsync/vsync/red.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int unsigned CLKS_PER_PIXEL = 4,
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned H_FP           = 16,
  parameter int unsigned H_SYNC         = 96,
  parameter int unsigned H_BP           = 48,
  parameter int unsigned V_ACTIVE       = 480,
  parameter int unsigned V_FP           = 10,
  parameter int unsigned V_SYNC         = 2,
  parameter int unsigned V_BP           = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [3:0] vga_r,
  output logic       pixel_valid,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic [3:0] pixel_value,
  output logic       frame_start,
  output logic       frame_done,
  output logic       locked,
  output logic       sync_error
);

  localparam int unsigned PW = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
  localparam int unsigned HTOT = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTOT = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_PIXEL - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(CLKS_PER_PIXEL / 2);
  localparam logic [9:0]    H_LAST    = 10'(HTOT - 1);
  localparam logic [9:0]    H_END     = 10'(HTOT);
  localparam logic [9:0]    V_LAST    = 10'(VTOT - 1);
  localparam logic [9:0]    V_END     = 10'(VTOT);
  localparam logic [9:0]    X0        = 10'(H_SYNC + H_BP);
  localparam logic [9:0]    X_END     = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]    Y0        = 10'(V_SYNC + V_BP - 1);
  localparam logic [9:0]    Y_END     = 10'(V_SYNC + V_BP - 1 + V_ACTIVE);
  localparam logic [9:0]    X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [9:0]    Y_LAST    = 10'(V_ACTIVE - 1);

  logic            w_hfall;
  logic            w_vfall;
  logic            w_vs_hit;
  logic            w_err;
  logic            w_sample;
  logic [9:0]      w_px;
  logic [9:0]      w_py;
  cap_state_t      r_state;
  cap_state_t      w_state_next;
  logic [3:0]      r_r_q;
  logic [PW-1:0]   r_phase;
  logic [9:0]      r_h_idx;
  logic [9:0]      r_line_idx;
  logic            r_vs_pend;
  logic            r_pixel_valid;
  logic [9:0]      r_pixel_x;
  logic [9:0]      r_pixel_y;
  logic [3:0]      r_pixel_value;
  logic            r_frame_start;
  logic            r_frame_done;
  logic            r_sync_error;

  vga_sync_edge u_hs_edge (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_sync  (hsync),
    .o_fall  (w_hfall)
  );

  vga_sync_edge u_vs_edge (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_sync  (vsync),
    .o_fall  (w_vfall)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= SEARCH;
    else        r_state <= w_state_next;
  end

  // Next state, timing-violation detection and sample-point decode.
  always_comb begin
    w_state_next = r_state;
    w_err        = 1'b0;
    w_vs_hit     = r_vs_pend | w_vfall;
    case (r_state)
      SEARCH: begin
        if (w_hfall && w_vs_hit) w_state_next = SYNCED;
      end
      SYNCED: begin
        if ((w_hfall && ((r_h_idx != H_LAST) || (r_phase != PH_LAST))) ||
            (r_h_idx == H_END) ||
            (w_vfall && (r_line_idx != V_LAST)) ||
            (r_line_idx == V_END)) begin
          w_err        = 1'b1;
          w_state_next = SEARCH;
        end
      end
      default: w_state_next = SEARCH;
    endcase
    w_px     = r_h_idx - X0;
    w_py     = r_line_idx - Y0;
    w_sample = (r_state == SYNCED) && !w_err && (r_phase == PH_SAMPLE) &&
               (r_h_idx >= X0) && (r_h_idx < X_END) &&
               (r_line_idx >= Y0) && (r_line_idx < Y_END);
  end

  // Pixel phase, column and line counters plus pending-vsync flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_r_q      <= '0;
      r_phase    <= '0;
      r_h_idx    <= '0;
      r_line_idx <= '0;
      r_vs_pend  <= 1'b0;
    end else begin
      r_r_q <= vga_r;
      if (w_hfall) begin
        r_phase <= '0;
        r_h_idx <= '0;
      end else if (r_phase == PH_LAST) begin
        r_phase <= '0;
        r_h_idx <= r_h_idx + 10'd1;
      end else begin
        r_phase <= r_phase + PW'(1);
      end
      if (w_hfall) begin
        if (w_vs_hit) r_line_idx <= '0;
        else          r_line_idx <= r_line_idx + 10'd1;
      end
      // An error discards any pending vsync so relock waits for a new one.
      if (w_err || w_hfall) r_vs_pend <= 1'b0;
      else if (w_vfall)     r_vs_pend <= 1'b1;
    end
  end

  // Registered pixel strobe, coordinates, frame markers and error pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pixel_valid <= 1'b0;
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_pixel_value <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_sync_error  <= 1'b0;
    end else begin
      r_pixel_valid <= w_sample;
      r_frame_start <= w_sample && (w_px == '0) && (w_py == '0);
      r_frame_done  <= w_sample && (w_px == X_LAST) && (w_py == Y_LAST);
      r_sync_error  <= w_err;
      if (w_sample) begin
        r_pixel_x     <= w_px;
        r_pixel_y     <= w_py;
        r_pixel_value <= r_r_q;
      end
    end
  end

  assign pixel_valid = r_pixel_valid;
  assign pixel_x     = r_pixel_x;
  assign pixel_y     = r_pixel_y;
  assign pixel_value = r_pixel_value;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign sync_error  = r_sync_error;
  assign locked      = (r_state == SYNCED);

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a reduced VGA timing so whole frames stay short.
module tb_vga_capture;

  localparam int CPP = 4;
  localparam int HA  = 8;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HBP = 2;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int HT  = HA + HFP + HS + HBP;   // 15
  localparam int VT  = VA + VFP + VS + VBP;   // 9
  localparam int HAS = HS + HBP;              // 5

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic [3:0] vga_r = 4'h0;
  logic       pixel_valid;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [3:0] pixel_value;
  logic       frame_start;
  logic       frame_done;
  logic       locked;
  logic       sync_error;

  int n_cmp = 0;
  int n_bad = 0;
  int n_strobe = 0, n_fs = 0, n_fd = 0, n_err = 0;
  int s_strobe = 0, s_fs = 0, s_fd = 0, s_err = 0;
  int cyc = 0;
  int src_mode = 0;
  int mon_sync = 0;

  always #5 clk = ~clk;

  vga_capture #(
    .CLKS_PER_PIXEL (CPP),
    .H_ACTIVE       (HA),
    .H_FP           (HFP),
    .H_SYNC         (HS),
    .H_BP           (HBP),
    .V_ACTIVE       (VA),
    .V_FP           (VFP),
    .V_SYNC         (VS),
    .V_BP           (VBP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hsync       (hsync),
    .vsync       (vsync),
    .vga_r       (vga_r),
    .pixel_valid (pixel_valid),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_value (pixel_value),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .locked      (locked),
    .sync_error  (sync_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid"}, pixel_valid, 0);
    check_eq({tag, "_x"},     pixel_x, 0);
    check_eq({tag, "_y"},     pixel_y, 0);
    check_eq({tag, "_value"}, pixel_value, 0);
    check_eq({tag, "_fs"},    frame_start, 0);
    check_eq({tag, "_fd"},    frame_done, 0);
    check_eq({tag, "_lock"},  locked, 0);
    check_eq({tag, "_err"},   sync_error, 0);
  endtask

  task automatic idle_clk();
    @(negedge clk);
    hsync = 1'b1;
    vsync = 1'b1;
    vga_r = 4'h0;
  endtask

  // One source line: sync, back porch, active, front porch; vsync toggles at
  // the start of horizontal active of line 0 and line VS.
  task automatic run_line(input int vc, input int len, input int rst_pix);
    int  pos;
    bit  act;
    for (int hc = 0; hc < len; hc++) begin
      for (int c = 0; c < CPP; c++) begin
        @(negedge clk);
        pos   = vc * HT + hc;
        act   = (hc >= HAS) && (hc < HAS + HA) && (vc >= VS + VBP) && (vc < VS + VBP + VA);
        hsync = (hc >= HS);
        vsync = !((pos >= HAS) && (pos < VS * HT + HAS));
        vga_r = act ? ((src_mode == 1) ? 4'(hc - HAS) : 4'hA) : 4'h0;
        if (hc == rst_pix && c == 0) reset = 1'b0;
        if (hc == rst_pix && c == 1) begin
          reset = 1'b1;
          check_zero("midrst");
        end
      end
    end
  endtask

  task automatic run_frame(input int short_vc, input int rst_vc);
    for (int vc = 0; vc < VT; vc++)
      run_line(vc, (vc == short_vc) ? HT - 1 : HT, (vc == rst_vc) ? HAS + 3 : -1);
  endtask

  task automatic snap();
    s_strobe = n_strobe;
    s_fs     = n_fs;
    s_fd     = n_fd;
    s_err    = n_err;
  endtask

  task automatic frame_check(input string tag, input int strobes, input int fs, input int fd,
                             input int errs, input logic lk);
    check_eq({tag, "_strobes"}, n_strobe - s_strobe, strobes);
    check_eq({tag, "_fs"},      n_fs - s_fs, fs);
    check_eq({tag, "_fd"},      n_fd - s_fd, fd);
    check_eq({tag, "_errs"},    n_err - s_err, errs);
    check_eq({tag, "_lock"},    locked, lk);
  endtask

  // Output monitor: expected pixel order, values, markers and strobe spacing.
  int exp_x = 0, exp_y = 0, last_cyc = 0, row_cyc = 0, seen_sync = 0;
  always @(negedge clk) begin
    cyc++;
    if (seen_sync != mon_sync) begin
      exp_x     = 0;
      exp_y     = 0;
      seen_sync = mon_sync;
    end
    if (sync_error) n_err++;
    if (pixel_valid) begin
      n_strobe++;
      if (frame_start) n_fs++;
      if (frame_done)  n_fd++;
      check_eq("pix_x", pixel_x, exp_x);
      check_eq("pix_y", pixel_y, exp_y);
      check_eq("pix_value", pixel_value, (src_mode == 1) ? 4'(exp_x) : 4'hA);
      check_eq("pix_fs", frame_start, (exp_x == 0) && (exp_y == 0));
      check_eq("pix_fd", frame_done, (exp_x == HA - 1) && (exp_y == VA - 1));
      if (exp_x != 0) begin
        check_eq("x_step", cyc - last_cyc, CPP);
      end else begin
        if (exp_y != 0) check_eq("row_step", cyc - row_cyc, HT * CPP);
        row_cyc = cyc;
      end
      last_cyc = cyc;
      exp_x++;
      if (exp_x == HA) begin
        exp_x = 0;
        exp_y++;
        if (exp_y == VA) exp_y = 0;
      end
    end else begin
      check_eq("marker_idle", {frame_start, frame_done}, 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset = 1'b1;
    repeat (40) idle_clk();
    check_eq("idle_lock", locked, 0);
    check_eq("idle_errs", n_err, 0);
    check_eq("idle_strobes", n_strobe, 0);

    // Frame 1: lock on the hsync fall following the first vsync fall.
    src_mode = 0;
    snap();
    run_line(0, HT, -1);
    check_eq("f1_lock_line0", locked, 0);
    run_line(1, HT, -1);
    check_eq("f1_lock_line1", locked, 1);
    for (int vc = 2; vc < VT; vc++) run_line(vc, HT, -1);
    frame_check("f1", HA * VA, 1, 1, 0, 1'b1);

    // Frame 2: ramp pattern.
    src_mode = 1;
    snap();
    run_frame(-1, -1);
    frame_check("f2", HA * VA, 1, 1, 0, 1'b1);

    // Frame 3: line 5 (row 1) one pixel short -> error at the next hsync fall.
    snap();
    run_frame(5, -1);
    frame_check("f3", 2 * HA, 1, 0, 1, 1'b0);
    mon_sync++;

    // Frame 4: relock after a fresh vsync fall.
    snap();
    run_frame(-1, -1);
    frame_check("f4", HA * VA, 1, 1, 0, 1'b1);

    // Frame 5: one-cycle reset in row 1.
    snap();
    run_frame(-1, 5);
    check_eq("f5_fs", n_fs - s_fs, 1);
    check_eq("f5_fd", n_fd - s_fd, 0);
    check_eq("f5_errs", n_err - s_err, 0);
    check_eq("f5_lock", locked, 0);
    mon_sync++;

    // Frame 6: capture resumes from row 0.
    snap();
    run_frame(-1, -1);
    frame_check("f6", HA * VA, 1, 1, 0, 1'b1);

    // Hsync held high: timeout once the column counter reaches the line total.
    snap();
    repeat (3) idle_clk();
    check_eq("to_err_early", sync_error, 0);
    check_eq("to_lock_early", locked, 1);
    idle_clk();
    check_eq("to_err_pulse", sync_error, 1);
    check_eq("to_lock_drop", locked, 0);
    idle_clk();
    check_eq("to_err_single", sync_error, 0);
    repeat (2 * HT * CPP) idle_clk();
    check_eq("to_errs", n_err - s_err, 1);
    check_eq("to_strobes", n_strobe - s_strobe, 0);
    check_eq("to_lock", locked, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receiving end of the VGA link driven by VGA_output. Consumes hsync/vsync/vga_r in the same clock domain and recovers pixel coordinates and grayscale values.
- Emits one registered pixel strobe per active pixel, plus frame markers and lock/error status.
- Used as the capture front-end for on-chip loopback of convolved frames and as a self-checking monitor in benches.
- Timing is 640x480@60 with negative-polarity syncs, one pixel every CLKS_PER_PIXEL system clocks.

Parameters:
- CLKS_PER_PIXEL, 4, system clocks per pixel (100 MHz / 25 MHz); must be >= 2.
- H_ACTIVE, 640, active pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync pulse width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, active lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync pulse width, in lines.
- V_BP, 33, vertical back porch, in lines.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous reset, active-low (0 = reset).
- hsync  in  1  horizontal sync, active-low.
- vsync  in  1  vertical sync, active-low.
- vga_r  in  4  red channel; grayscale source (G and B are ignored).
- pixel_valid  out  1  one-cycle strobe per captured active pixel.
- pixel_x  out  10  column 0..639; valid with pixel_valid.
- pixel_y  out  10  row 0..479; valid with pixel_valid.
- pixel_value  out  4  sampled vga_r.
- frame_start  out  1  one-cycle pulse together with pixel (0,0).
- frame_done  out  1  one-cycle pulse together with pixel (639,479).
- locked  out  1  high while in SYNCED state.
- sync_error  out  1  one-cycle pulse on a timing violation.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All outputs 0. State SEARCH. All counters 0. Edge registers loaded with 1 (idle sync level).
  - Applies mid-frame with no residual strobes.
- Input stage:
  - hsync, vsync and vga_r are registered once (hs_q, vs_q, r_q), then delayed once more for edge detection.
  - A fall is the cycle where the _q signal is 0 and its delayed copy is 1.
- Horizontal counting, on every hsync fall:
  - phase <= 0, h_idx <= 0.
  - Otherwise phase counts 0..CLKS_PER_PIXEL-1, and h_idx increments when phase wraps.
- Sample point: phase == CLKS_PER_PIXEL/2 and h_idx in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE).
  - pixel_x = h_idx-(H_SYNC+H_BP).
- Vertical counting:
  - A vsync fall sets vs_pend.
  - On the next hsync fall (or the same cycle), line_idx <= 0 and vs_pend is cleared. Other hsync falls increment line_idx.
  - Active rows are line_idx in [V_SYNC+V_BP-1, V_SYNC+V_BP-1+V_ACTIVE), with pixel_y = line_idx-(V_SYNC+V_BP-1).
  - The -1 is required because VGA_output toggles vsync at the start of horizontal active.
- Output latency: pixel_valid/x/y/value are registered and appear 1 cycle after the sample point, i.e. 3 cycles after vga_r is driven.
- States (2-state FSM):
  - SEARCH: no pixel strobes, locked=0. Moves to SYNCED at the hsync fall that clears vs_pend.
  - SYNCED: locked=1, strobes enabled. Moves to SEARCH with a sync_error pulse on:
    - hsync fall with h_idx != H_TOTAL-1 or phase != CLKS_PER_PIXEL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800;
    - h_idx reaching H_TOTAL with no hsync fall (timeout);
    - vsync fall with line_idx != V_TOTAL-1, where V_TOTAL = 525;
    - line_idx reaching V_TOTAL.
- Error recovery:
  - A pixel strobe due in the same cycle as an error is suppressed.
  - A frame with an error never produces frame_done.
  - Relock needs a fresh vsync fall.
- First lock: the first vsync fall after reset in SEARCH is accepted without the line-count check.
- Simultaneous hsync and vsync falls: the hsync fall resets line_idx to 0 in that cycle.
- Counter widths and wrap-around:
  - h_idx and line_idx are 10 bits, with the timeout checked before wrap.
  - The phase width is clog2(CLKS_PER_PIXEL).

Decomposition:
- Package vga_capture_pkg holds:
  - timing constants H_TOTAL, V_TOTAL, H_ACT_START = H_SYNC+H_BP, V_ACT_START = V_SYNC+V_BP-1;
  - typedef enum logic {SEARCH, SYNCED} cap_state_t.
- One sub-module, vga_sync_edge: 1-bit register plus delayed copy with a fall output, instantiated for hsync and for vsync.

Test Plan:
- Reset low for 3 cycles, syncs idle high -> all outputs 0, locked=0. After release with no syncs, locked stays 0 indefinitely.
- Drive VGA_output with display_image=1, grayscale_pixel=4'hA -> locked rises on the first hsync fall after the first vsync fall. The next frame yields exactly 307200 strobes, all value 4'hA. frame_start is seen with (0,0) and frame_done with (639,479).
- Synthetic source with vga_r = x[3:0] -> pixel_value == pixel_x[3:0] for every strobe. pixel_x increments by 1 every 4 cycles within a row, and pixel_y increments once per 3200 cycles.
- Shorten one line to 799 pixels mid-frame -> single sync_error pulse, locked=0, no strobes until the next vsync fall, then relock and frame_start.
- Assert reset for 1 cycle at row 200 -> all outputs 0 the next cycle, state SEARCH. Capture resumes at row 0 of the following frame.
- Hold hsync high for 900 pixel times while SYNCED -> sync_error pulse when h_idx reaches 800, locked=0.
